// File: rtl/adder_arbiter.sv
// Shared 16-bit carry-lookahead adder behind a round-robin arbiter.
// Operands are registered in S1, results are registered in S2, and S2 drives the tagged response port.

module CLA_16_bit_ripple (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [4:0] carry_s;

    // One 4-bit lookahead block: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | ((&p) & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Four lookahead blocks, with the carry rippling between blocks
    always_comb begin
        carry_s    = 5'd0;
        sum        = 16'd0;
        carry_s[0] = cin;
        for (int k = 0; k < 4; k++) begin
            {carry_s[k+1], sum[4*k +: 4]} = cla4(a[4*k +: 4], b[4*k +: 4], carry_s[k]);
        end
        cout = carry_s[4];
    end

endmodule

module adder_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2:0]           resp_id,
    output logic [15:0]          resp_sum,
    output logic                 resp_cout,
    output logic                 busy
);

    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [2:0]      ptr_r;
    logic            s1_valid_r;
    logic [2:0]      s1_id_r;
    logic [15:0]     s1_a_r;
    logic [15:0]     s1_b_r;
    logic            s1_cin_r;
    logic            resp_valid_r;
    logic [2:0]      resp_id_r;
    logic [15:0]     resp_sum_r;
    logic            resp_cout_r;

    logic            s2_free_s;
    logic            s1_free_s;
    logic            s1_adv_s;
    logic            accept_s;
    logic            found_s;
    logic [2:0]      winner_s;
    logic [3:0]      scan_idx_s;
    logic [NREQ-1:0] grant_s;
    logic [15:0]     a_sel_s;
    logic [15:0]     b_sel_s;
    logic            cin_sel_s;
    logic [2:0]      ptr_nxt_s;
    logic [15:0]     sum_s;
    logic            cout_s;

    // Pipeline advance conditions
    always_comb begin
        s2_free_s = !resp_valid_r || resp_ready;
        s1_free_s = !s1_valid_r || s2_free_s;
        s1_adv_s  = s1_valid_r && s2_free_s;
    end

    // Round-robin scan starting at ptr; only the winner's valid can reach req_ready
    always_comb begin
        found_s    = 1'b0;
        winner_s   = 3'd0;
        scan_idx_s = 4'd0;
        for (int off = 0; off < NREQ; off++) begin
            scan_idx_s = {1'b0, ptr_r} + 4'(off);
            scan_idx_s = (scan_idx_s >= 4'(NREQ)) ? (scan_idx_s - 4'(NREQ)) : scan_idx_s;
            if (!found_s && (|(req_valid & (ONE_HOT0 << scan_idx_s)))) begin
                found_s  = 1'b1;
                winner_s = scan_idx_s[2:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant is held off during reset and while S1 cannot take a new entry
    always_comb begin
        grant_s   = found_s ? (ONE_HOT0 << winner_s) : {NREQ{1'b0}};
        req_ready = (rst_n && s1_free_s) ? grant_s : {NREQ{1'b0}};
        accept_s  = |req_ready;
        ptr_nxt_s = (winner_s == 3'(NREQ-1)) ? 3'd0 : (winner_s + 3'd1);
    end

    // Operand mux for the winning requester
    always_comb begin
        a_sel_s   = 16'd0;
        b_sel_s   = 16'd0;
        cin_sel_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_sel_s   = (winner_s == 3'(i)) ? req_a[16*i +: 16] : a_sel_s;
            b_sel_s   = (winner_s == 3'(i)) ? req_b[16*i +: 16] : b_sel_s;
            cin_sel_s = (winner_s == 3'(i)) ? req_cin[i]        : cin_sel_s;
        end
    end

    CLA_16_bit_ripple u_cla (
        .a    (s1_a_r),
        .b    (s1_b_r),
        .cin  (s1_cin_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Round-robin pointer moves past the winner on every acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 3'd0;
        end else if (accept_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // S1 operand register: load on accept, empty when it moves on without a refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_id_r    <= 3'd0;
            s1_a_r     <= 16'd0;
            s1_b_r     <= 16'd0;
            s1_cin_r   <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_id_r    <= winner_s;
            s1_a_r     <= a_sel_s;
            s1_b_r     <= b_sel_s;
            s1_cin_r   <= cin_sel_s;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // S2 result register: capture the adder output, clear on an unrefilled drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            resp_id_r    <= 3'd0;
            resp_sum_r   <= 16'd0;
            resp_cout_r  <= 1'b0;
        end else if (s1_adv_s) begin
            resp_valid_r <= 1'b1;
            resp_id_r    <= s1_id_r;
            resp_sum_r   <= sum_s;
            resp_cout_r  <= cout_s;
        end else if (resp_valid_r && resp_ready) begin
            resp_valid_r <= 1'b0;
        end else begin
            resp_valid_r <= resp_valid_r;
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_sum   = resp_sum_r;
    assign resp_cout  = resp_cout_r;
    assign busy       = s1_valid_r || resp_valid_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (NREQ=4): vector table plus hand-written
// multi-cycle sequences for round-robin order, fairness, backpressure and reset.

module tb_adder_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_cin;
    logic        resp_valid;
    logic        resp_ready;
    logic [2:0]  resp_id;
    logic [15:0] resp_sum;
    logic        resp_cout;
    logic        busy;

    int total;
    int bad;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    vec_t        vecs[8];
    logic [3:0]  g;
    logic [16:0] ref_r;
    int          accepted;
    int          nresp;
    int          ngrant;

    adder_arbiter #(.NREQ(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {16'd0, c};
    endfunction

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b, input logic c);
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_cin[id]        = c;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
        chk({tag, "_resp_id"},    32'(resp_id),    32'd0);
        chk({tag, "_resp_sum"},   32'(resp_sum),   32'd0);
        chk({tag, "_resp_cout"},  32'(resp_cout),  32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        req_valid  = 4'd0;
        resp_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        req_valid  = 4'd0;
        req_a      = 64'd0;
        req_b      = 64'd0;
        req_cin    = 4'd0;
        resp_ready = 1'b1;

        vecs[0] = '{2, 16'h1234, 16'h0F0F, 1'b1, 16'h2144, 1'b0};
        vecs[1] = '{0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{3, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{2, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0};
        vecs[5] = '{0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[6] = '{1, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        vecs[7] = '{3, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

        // All four requesters valid while still in reset
        #3;
        for (int i = 0; i < 4; i++) set_req(i, 16'(i * 256), 16'h0011, 1'(i % 2));
        req_valid = 4'hF;
        #1;
        chk_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Grants 0,1,2,3 on consecutive edges, responses two edges later
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("rr_ready_c%0d", c), 32'(req_ready), (c < 4) ? (32'd1 << c) : 32'd0);
            if (c >= 2) begin
                ref_r = ref_add(16'((c - 2) * 256), 16'h0011, 1'((c - 2) % 2));
                chk($sformatf("rr_valid_c%0d", c), 32'(resp_valid), 32'd1);
                chk($sformatf("rr_id_c%0d", c),    32'(resp_id),    32'(c - 2));
                chk($sformatf("rr_sum_c%0d", c),   32'(resp_sum),   32'(ref_r[15:0]));
            end else begin
                chk($sformatf("rr_valid_c%0d", c), 32'(resp_valid), 32'd0);
            end
            @(posedge clk);
            #1;
            if (c < 4) req_valid[c] = 1'b0;
        end
        // Pointer is back at 0: requesters 0 and 1 both valid, 0 wins
        req_valid = 4'b0011;
        @(negedge clk);
        chk("rr_ptr_wrap", 32'(req_ready), 32'h1);
        chk("rr_idle_busy", 32'(busy), 32'd0);
        req_valid = 4'd0;

        // Table of single transactions
        for (int v = 0; v < 8; v++) begin
            @(posedge clk);
            #1;
            set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].cin);
            req_valid = 4'd1 << vecs[v].id;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'd1 << vecs[v].id);
            @(posedge clk);
            #1;
            req_valid = 4'd0;
            @(negedge clk);
            chk($sformatf("vec%0d_early", v), 32'(resp_valid), 32'd0);
            chk($sformatf("vec%0d_busy", v),  32'(busy),       32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", v), 32'(resp_valid), 32'd1);
            chk($sformatf("vec%0d_id", v),    32'(resp_id),    32'(vecs[v].id));
            chk($sformatf("vec%0d_sum", v),   32'(resp_sum),   32'(vecs[v].sum));
            chk($sformatf("vec%0d_cout", v),  32'(resp_cout),  32'(vecs[v].cout));
        end

        // Fairness: requesters 0 and 2 held valid continuously
        do_reset();
        set_req(0, 16'h0100, 16'h0001, 1'b0);
        set_req(2, 16'h0200, 16'h0002, 1'b0);
        req_valid = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("fair_ready_c%0d", c), 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h4);
            if (c >= 2) begin
                chk($sformatf("fair_id_c%0d", c),  32'(resp_id),  (c % 2 == 0) ? 32'd0 : 32'd2);
                chk($sformatf("fair_sum_c%0d", c), 32'(resp_sum), (c % 2 == 0) ? 32'h0101 : 32'h0202);
            end
            @(posedge clk);
        end

        // Backpressure: resp_ready low for 5 cycles, then drain in order
        do_reset();
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 16'(16'h1111 * (i + 1)), 16'hF000, 1'b1);
        req_valid = 4'hF;
        accepted  = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            g = req_ready;
            chk($sformatf("bp_ready_c%0d", c), 32'(g), (c == 0) ? 32'h1 : ((c == 1) ? 32'h2 : 32'h0));
            accepted += $countones(g);
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
        end
        chk("bp_accepted", 32'(accepted), 32'd2);
        chk("bp_hold_valid", 32'(resp_valid), 32'd1);
        chk("bp_hold_id", 32'(resp_id), 32'd0);
        chk("bp_hold_busy", 32'(busy), 32'd1);
        resp_ready = 1'b1;
        nresp  = 0;
        ngrant = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            g = req_ready;
            if (g != 4'd0) begin
                chk($sformatf("bp_grant%0d", ngrant), 32'(g), 32'd4 << ngrant);
                ngrant++;
            end
            if (resp_valid) begin
                ref_r = ref_add(16'(16'h1111 * (nresp + 1)), 16'hF000, 1'b1);
                chk($sformatf("bp_resp%0d_id", nresp),   32'(resp_id),   32'(nresp));
                chk($sformatf("bp_resp%0d_sum", nresp),  32'(resp_sum),  32'(ref_r[15:0]));
                chk($sformatf("bp_resp%0d_cout", nresp), 32'(resp_cout), 32'(ref_r[16]));
                nresp++;
            end
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
        end
        chk("bp_resp_count", 32'(nresp), 32'd4);
        chk("bp_grant_count", 32'(ngrant), 32'd2);
        chk("bp_drained_busy", 32'(busy), 32'd0);

        // Reset with both stages full
        do_reset();
        resp_ready = 1'b0;
        set_req(0, 16'h4321, 16'h1111, 1'b0);
        set_req(1, 16'h0F00, 16'h00F0, 1'b1);
        req_valid = 4'b0011;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        chk("mid_full_valid", 32'(resp_valid), 32'd1);
        chk("mid_full_busy", 32'(busy), 32'd1);
        chk("mid_full_sum", 32'(resp_sum), 32'h5432);
        set_req(1, 16'h2000, 16'h0345, 1'b1);
        set_req(3, 16'h3000, 16'h0001, 1'b0);
        req_valid = 4'b1010;
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("mid_ptr0_grant", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid = 4'd0;
        @(negedge clk);
        chk("mid_early", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_valid", 32'(resp_valid), 32'd1);
        chk("mid_id", 32'(resp_id), 32'd1);
        chk("mid_sum", 32'(resp_sum), 32'h2346);
        chk("mid_cout", 32'(resp_cout), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one registered 16-bit carry-lookahead adder (`CLA_16_bit_ripple`) between up to eight requesters. Each requester presents an operand pair and carry-in through a valid/ready handshake. A round-robin arbiter grants one request per cycle. Results return on a single tagged response port with backpressure, so several producer blocks in the datapath can use one adder at one result per clock.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input NREQ: bit i high = requester i presents a request.
- `req_ready` output NREQ: bit i high = request i is accepted at this edge; at most one bit high.
- `req_a` input 16*NREQ: operand A; slice [16i+15:16i] belongs to requester i.
- `req_b` input 16*NREQ: operand B, same slicing as `req_a`.
- `req_cin` input NREQ: carry-in per requester.
- `resp_valid` output 1: response stage holds a result.
- `resp_ready` input 1: consumer accepts the response at this edge.
- `resp_id` output 3: index of the requester that issued the result.
- `resp_sum` output 16: `(a + b + cin) mod 2^16`.
- `resp_cout` output 1: carry out of bit 15.
- `busy` output 1: high while either pipeline stage holds a valid entry.

## Operation
- Two-stage pipeline:
  - S1 (operand register): `s1_valid`, id, a, b, cin. Feeds a combinational `CLA_16_bit_ripple` instance.
  - S2 (result register): drives `resp_*` directly.
- Accepted requests enter S1 and complete in issue order. No reordering, no dropping.
- Handshakes:
  - Request i transfers on an edge where `req_valid[i] && req_ready[i]`.
  - Response transfers on an edge where `resp_valid && resp_ready`.
  - Once `req_valid[i]` is high, requester i holds it and its operands stable until accepted. Behaviour otherwise is undefined and is not checked.
- Pipeline advance:
  - `s2_free = !resp_valid || resp_ready`.
  - `s1_free = !s1_valid || s2_free`.
  - S1 moves to S2 when `s1_valid && s2_free`.
  - S2 clears on a response transfer that has no simultaneous S1 refill.
- Arbitration (combinational):
  - Round-robin pointer `ptr` (3 bits, range 0..NREQ-1).
  - Winner = first i with `req_valid[i]`, scanning ptr, ptr+1, … mod NREQ.
  - `req_ready` = one-hot(winner) when `s1_free`; otherwise all zeros.
  - `req_ready` never depends on `req_valid` of a non-winning requester.
  - On every accepted request, `ptr <= (winner + 1) mod NREQ`. With no acceptance, ptr holds.
- Arithmetic: exactly 16-bit operands plus a 1-bit cin; 17-bit result split into `resp_sum`/`resp_cout`. No signed handling; signed overflow is the consumer's concern.
- Reset (async assert of `rst_n` low, including mid-operation):
  - Both valids clear immediately and in-flight entries are discarded.
  - `ptr = 0`; `req_ready = 0`.
  - `resp_valid = 0`, `resp_id = 0`, `resp_sum = 0`, `resp_cout = 0`, `busy = 0`.
  - Deassertion is synchronised by the system. The first acceptance is possible on the first edge after release.

## Timing
- Latency: request accepted at edge k → `resp_valid` high after edge k+1 with its result (2 edges, matching the registered adder wrapper), provided S2 was free.
- Throughput: one accept and one response per cycle while `resp_ready` stays high.
- Stall:
  - `resp_ready` low with S2 full → S2 holds and S1 holds.
  - `req_ready` drops to 0 the same cycle S1 is full and cannot advance.
  - Nothing is lost; at most 2 results are buffered.
- Simultaneous events:
  - Response drain and new accept on the same edge are both legal.
  - S1→S2 and a new S1 load on the same edge are legal.
- `busy = s1_valid || resp_valid`, registered-derived, no combinational path from inputs.
- Combinational paths:
  - From `req_valid` and `resp_ready` to `req_ready` only.
  - No path from `req_a`/`req_b` to any output.

## Test plan
- Single request, NREQ=4, requester 2 presents a=0x1234, b=0x0F0F, cin=1 → `req_ready` = 4'b0100 at edge k; after edge k+1: `resp_valid` = 1, `resp_id` = 2, `resp_sum` = 0x2144, `resp_cout` = 0.
- All four requesters valid from reset, `resp_ready` = 1 → grants 0,1,2,3 on consecutive edges; responses id 0,1,2,3 on consecutive cycles; `ptr` returns to 0.
- Wrap and carry: a=0xFFFF, b=0x0001, cin=0 → sum 0x0000, cout 1. Also a=0xFFFF, b=0xFFFF, cin=1 → sum 0xFFFF, cout 1.
- Fairness: requesters 0 and 2 held valid continuously → grants alternate 0,2,0,2; requester 0 is never granted twice in a row.
- Backpressure: stream of 4 requests with `resp_ready` low for 5 cycles → exactly 2 accepted, `req_ready` stays 0; after `resp_ready` rises, all 4 results emerge in order with correct ids.
- Reset mid-operation: assert `rst_n` low with both stages full → `resp_valid`, `busy`, `req_ready`, `resp_*` go to 0 without waiting for a clock edge. After release, the next request completes with 2-edge latency and is granted from pointer 0.
